regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 4x16 register file between two writeback

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two requesters that share the register file
// write port. Requester A carries ALU results; requester B carries load returns.
// Each requester holds valid, addr and data stable until it sees its ready.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  // Requester side: presents writes and watches for acceptance.
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  // Arbiter side: sees both requests and returns the accept strobes.
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the single write port of the
// 4x16 register file between requester A (ALU) and requester B (load return).
// One accepted write per cycle is registered and drives the write port on the
// following cycle. Writes to addresses >= NUM_REGS are dropped and flagged on
// the sticky err_oor output.
// Optional feature: define REGFILE_BYPASS_EN to forward the registered write
// data onto the read ports when the read address matches the write address.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  regfile_wb_arbiter_if.slave wb,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrData,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [DATA_W-1:0] rf_rd_data_a,
  output logic [DATA_W-1:0] fwd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              err_oor
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_id_t;

  grant_id_t         last_grant;
  grant_id_t         last_grant_next;
  logic              grant_a;
  logic              grant_b;
  logic              any_grant;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Round-robin state: remembers who was served last so a tie goes to the other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Pick this cycle's winner; nothing is granted during reset or hold.
  always_comb begin
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;
    if (!rst && !hold) begin
      if (wb.a_valid && wb.b_valid) begin
        if (last_grant == GRANT_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = wb.a_valid;
        grant_b = wb.b_valid;
      end
    end
    if (grant_a) begin
      last_grant_next = GRANT_A;
    end else if (grant_b) begin
      last_grant_next = GRANT_B;
    end
  end

  assign any_grant  = grant_a | grant_b;
  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  // Steer the winner's address and data toward the output stage and range-check it.
  always_comb begin
    sel_addr = grant_b ? wb.b_addr : wb.a_addr;
    sel_data = grant_b ? wb.b_data : wb.a_data;
    in_range = (32'(sel_addr) < 32'(NUM_REGS));
  end

  // Output stage: an accepted write reaches the register file one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write  <= 1'b0;
      rf_wrAddr <= '0;
      rf_wrData <= '0;
      err_oor   <= 1'b0;
    end else begin
      rf_write <= any_grant && in_range;
      if (any_grant) begin
        rf_wrAddr <= sel_addr;
        rf_wrData <= sel_data;
        if (!in_range) begin
          err_oor <= 1'b1;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read-during-write returns the data being written this cycle.
  always_comb begin
    fwd_data_a = (rf_write && (rf_wrAddr == rd_addr_a)) ? rf_wrData : rf_rd_data_a;
    fwd_data_b = (rf_write && (rf_wrAddr == rd_addr_b)) ? rf_wrData : rf_rd_data_b;
  end
`else
  // Without bypass the read addresses only matter to the register file itself.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_a, rd_addr_b};
  assign fwd_data_a     = rf_rd_data_a;
  assign fwd_data_b     = rf_rd_data_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wrAddr;
  logic [DATA_W-1:0] rf_wrData;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rf_rd_data_a;
  logic [DATA_W-1:0] rf_rd_data_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic              err_oor;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .wb(wb),
    .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .rd_addr_a(rd_addr_a), .rf_rd_data_a(rf_rd_data_a), .fwd_data_a(fwd_data_a),
    .rd_addr_b(rd_addr_b), .rf_rd_data_b(rf_rd_data_b), .fwd_data_b(fwd_data_b),
    .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: what the write port must show next cycle, and who was served last.
  bit              exp_known = 1'b0;
  bit              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit              m_err;
  int              m_last_served = 1;  // 0 = A, 1 = B
  bit              a_acc = 1'b0;
  bit              b_acc = 1'b0;

  // The register file behind the write port, written from the DUT's outputs.
  logic [DATA_W-1:0] regs [NUM_REGS];

  always @(posedge clk) begin
    if (rf_write) regs[rf_wrAddr[1:0]] <= rf_wrData;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then return after the mid-cycle check.
  task automatic applyStimulus(input logic r, input logic h,
                               input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                               input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    @(posedge clk);
    #1;
    rst        = r;
    hold       = h;
    wb.a_valid = av;
    wb.a_addr  = aa;
    wb.a_data  = ad;
    wb.b_valid = bv;
    wb.b_addr  = ba;
    wb.b_data  = bd;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] pickAddr();
    if ($urandom_range(0, 9) == 0) return 3'(4 + $urandom_range(0, 3));
    return 3'($urandom_range(0, 3));
  endfunction

  // Every cycle: compare DUT outputs against the model, then advance the model.
  always @(negedge clk) begin
    bit ga;
    bit gb;
    logic [DATA_W-1:0] ef_a;
    logic [DATA_W-1:0] ef_b;
    ga = 1'b0;
    gb = 1'b0;
    if (!rst && !hold) begin
      if (wb.a_valid && wb.b_valid) begin
        ga = (m_last_served == 1);
        gb = !ga;
      end else begin
        ga = wb.a_valid;
        gb = wb.b_valid;
      end
    end
    checkOutput("ready", 32'({wb.a_ready, wb.b_ready}), 32'({ga, gb}));
    if (exp_known) begin
      checkOutput("rf_write", 32'(rf_write), 32'(m_write));
      checkOutput("rf_wrAddr", 32'(rf_wrAddr), 32'(m_addr));
      checkOutput("rf_wrData", 32'(rf_wrData), 32'(m_data));
      checkOutput("err_oor", 32'(err_oor), 32'(m_err));
      ef_a = rf_rd_data_a;
      ef_b = rf_rd_data_b;
`ifdef REGFILE_BYPASS_EN
      if (m_write && m_addr == rd_addr_a) ef_a = m_data;
      if (m_write && m_addr == rd_addr_b) ef_b = m_data;
`endif
      checkOutput("fwd_data_a", 32'(fwd_data_a), 32'(ef_a));
      checkOutput("fwd_data_b", 32'(fwd_data_b), 32'(ef_b));
    end
    a_acc = wb.a_ready;
    b_acc = wb.b_ready;
    if (rst) begin
      m_write       = 1'b0;
      m_addr        = '0;
      m_data        = '0;
      m_err         = 1'b0;
      m_last_served = 1;
      exp_known     = 1'b1;
    end else if (ga || gb) begin
      m_addr        = ga ? wb.a_addr : wb.b_addr;
      m_data        = ga ? wb.a_data : wb.b_data;
      m_write       = (int'(m_addr) < NUM_REGS);
      if (!m_write) m_err = 1'b1;
      m_last_served = ga ? 0 : 1;
    end else begin
      m_write = 1'b0;
    end
  end

  initial begin
    bit                pa;
    bit                pb;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] ad;
    logic [DATA_W-1:0] bd;
    rst = 1'b1; hold = 1'b0;
    wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = '0; wb.b_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rf_rd_data_a = '0; rf_rd_data_b = '0;

    // Reset with A requesting: nothing accepted, write port idle; A wins the first tie.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'h0101, 1'b0, 3'd0, 16'h0000);
    checkOutput("t1_rst_ready", 32'({wb.a_ready, wb.b_ready}), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'h0101, 1'b0, 3'd0, 16'h0000);
    checkOutput("t1_rst_ready2", 32'({wb.a_ready, wb.b_ready}), 32'd0);
    checkOutput("t1_rst_rf_write", 32'(rf_write), 32'd0);
    checkOutput("t1_rst_err", 32'(err_oor), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h0101, 1'b1, 3'd1, 16'h0202);
    checkOutput("t1_first_tie", 32'({wb.a_ready, wb.b_ready}), 32'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0202);
    checkOutput("t1_b_after_a", 32'({wb.a_ready, wb.b_ready}), 32'b01);
    checkOutput("t1_a_write_data", 32'(rf_wrData), 32'h0101);

    // Single A write: visible on the port one cycle later, then the port goes idle.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0000);
    checkOutput("t2_a_ready", 32'(wb.a_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t2_rf_write", 32'(rf_write), 32'd1);
    checkOutput("t2_rf_wrAddr", 32'(rf_wrAddr), 32'd2);
    checkOutput("t2_rf_wrData", 32'(rf_wrData), 32'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t2_rf_write_off", 32'(rf_write), 32'd0);
    checkOutput("t2_wrAddr_hold", 32'(rf_wrAddr), 32'd2);

    // A lone B write so that the next tie belongs to A.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0B0B);
    checkOutput("t3_pre_b_ready", 32'(wb.b_ready), 32'd1);

    // Both requesters hammer register 1: grants alternate and B's value lands last.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd1, 16'hBBBB);
      checkOutput("t3_alternate", 32'({wb.a_ready, wb.b_ready}), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t3_reg1_final", 32'(regs[1]), 32'hBBBB);

    // Out-of-range B write: accepted but dropped, and the error flag sticks.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hDEAD);
    checkOutput("t4_b_ready", 32'(wb.b_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t4_rf_write", 32'(rf_write), 32'd0);
    checkOutput("t4_err", 32'(err_oor), 32'd1);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t4_err_sticky", 32'(err_oor), 32'd1);

    // Hold with both pending: the registered write drains, then B (non-last) resumes.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 16'h0000);
    checkOutput("t5_a_ready", 32'(wb.a_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 16'h6666, 1'b1, 3'd0, 16'h7777);
      checkOutput("t5_hold_ready", 32'({wb.a_ready, wb.b_ready}), 32'd0);
      checkOutput("t5_hold_write", 32'(rf_write), (k == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'h6666, 1'b1, 3'd0, 16'h7777);
    checkOutput("t5_resume_b", 32'({wb.a_ready, wb.b_ready}), 32'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'h6666, 1'b0, 3'd0, 16'h0000);
    checkOutput("t5_then_a", 32'({wb.a_ready, wb.b_ready}), 32'b10);

    // Read-during-write on port A with the raw regfile data still zero.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000);
    rd_addr_a = 3'd3;
    rf_rd_data_a = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
`ifdef REGFILE_BYPASS_EN
    checkOutput("t6_fwd_a", 32'(fwd_data_a), 32'hBEEF);
`else
    checkOutput("t6_fwd_a", 32'(fwd_data_a), 32'h0000);
`endif
    rd_addr_a = 3'd0;

    // Reset clears the sticky error.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("t7_err_cleared", 32'(err_oor), 32'd0);

    // Randomized traffic; each requester keeps its request until it sees ready.
    pa = 1'b0; pb = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pa || a_acc) begin
        pa = ($urandom_range(0, 3) != 0);
        aa = pickAddr();
        ad = 16'($urandom);
      end
      if (!pb || b_acc) begin
        pb = ($urandom_range(0, 3) != 0);
        ba = pickAddr();
        bd = 16'($urandom);
      end
      rd_addr_a    = 3'($urandom_range(0, 3));
      rd_addr_b    = 3'($urandom_range(0, 3));
      rf_rd_data_a = 16'($urandom);
      rf_rd_data_b = 16'($urandom);
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 6) == 0),
                    pa, aa, ad, pb, ba, bd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
